univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/usr_pkg.sv | 21 ++
 rtl/usr_bit_cell.sv | 43 ++++
 rtl/univ_shift_reg.sv | 155 +++++++++++++++
 tb/tb_univ_shift_reg.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared types and op encodings for the universal shift register.
// The rotate-on-shift option is selected by the USR_ROTATE_EN macro in univ_shift_reg.
package usr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } usr_state_e;

    // The bit-cell mux select uses the same encoding as the manual op port.
    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    function automatic logic [1:0] burst_op(input logic dir_left);
        return dir_left ? OP_SHL : OP_SHR;
    endfunction

endpackage

// File: rtl/usr_bit_cell.sv
// One register bit: 4:1 select (hold / higher neighbour / lower neighbour / load)
// feeding a synchronously reset flop with true and complement outputs.
module usr_bit_cell
    import usr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sel,
    input  logic       d,
    input  logic       from_hi,
    input  logic       from_lo,
    output logic       q,
    output logic       qb
);

    logic q_r;
    logic next_s;

    // Next-state select for this bit
    always_comb begin
        next_s = q_r;
        case (sel)
            OP_HOLD: next_s = q_r;
            OP_SHR:  next_s = from_hi;
            OP_SHL:  next_s = from_lo;
            OP_LOAD: next_s = d;
            default: next_s = q_r;
        endcase
    end

    // Bit storage with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= 1'b0;
        end else begin
            q_r <= next_s;
        end
    end

    assign q  = q_r;
    assign qb = ~q_r;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with manual ops and a load-then-shift burst sequencer.
// Define USR_ROTATE_EN to make every shift rotate (fill = bit shifted out, sin ignored).
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIR   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 op,
    input  logic [WIDTH-1:0]           d,
    input  logic                       sin,
    input  logic                       start,
    input  logic [$clog2(WIDTH+1)-1:0] len,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           qb,
    output logic                       sout,
    output logic                       busy,
    output logic                       done
);

    localparam int               CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_MAX  = CW'(WIDTH);
    localparam logic [1:0]       BURST_OP = burst_op(DIR != 0);

    usr_state_e       state_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [CW-1:0]    len_clamped_s;
    logic [1:0]       sel_s;
    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] qb_s;
    logic [WIDTH-1:0] hi_vec_s;
    logic [WIDTH-1:0] lo_vec_s;
    logic             fill_hi_s;
    logic             fill_lo_s;

`ifdef USR_ROTATE_EN
    logic unused_sin_s;
    assign unused_sin_s = sin;
    assign fill_hi_s    = q_s[0];
    assign fill_lo_s    = q_s[WIDTH-1];
`else
    assign fill_hi_s    = sin;
    assign fill_lo_s    = sin;
`endif

    // Neighbour taps: right shift pulls from the bit above, left shift from the bit below.
    assign hi_vec_s = {fill_hi_s, q_s[WIDTH-1:1]};
    assign lo_vec_s = {q_s[WIDTH-2:0], fill_lo_s};

    // Clamp the requested burst length to the register width
    always_comb begin
        len_clamped_s = len;
        if (len > CNT_MAX) begin
            len_clamped_s = CNT_MAX;
        end else begin
            len_clamped_s = len;
        end
    end

    // Per-cycle select for every bit cell; start wins over a manual op in IDLE
    always_comb begin
        sel_s = OP_HOLD;
        case (state_r)
            IDLE: begin
                if (start) begin
                    sel_s = OP_LOAD;
                end else if (en) begin
                    sel_s = op;
                end else begin
                    sel_s = OP_HOLD;
                end
            end
            RUN: begin
                if (cnt_r != CNT_ZERO) begin
                    sel_s = BURST_OP;
                end else begin
                    sel_s = OP_HOLD;
                end
            end
            DONE:    sel_s = OP_HOLD;
            default: sel_s = OP_HOLD;
        endcase
    end

    // Burst sequencer with registered busy/done flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= RUN;
                        cnt_r   <= len_clamped_s;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r   <= cnt_r - CNT_ONE;
                    end else begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        usr_bit_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .sel     (sel_s),
            .d       (d[i]),
            .from_hi (hi_vec_s[i]),
            .from_lo (lo_vec_s[i]),
            .q       (q_s[i]),
            .qb      (qb_s[i])
        );
    end

    assign q    = q_s;
    assign qb   = qb_s;
    assign sout = (DIR != 0) ? q_s[WIDTH-1] : q_s[0];
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, DIR=0) against an arithmetic model.
module tb_univ_shift_reg;

    localparam int TB_DIR = 0;
`ifdef USR_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, en, sin, start;
    logic [1:0] op;
    logic [7:0] d;
    logic [3:0] len;
    logic [7:0] q, qb;
    logic       sout, busy, done;

    int total = 0;
    int bad   = 0;
    logic [7:0] mq;

    univ_shift_reg #(.WIDTH(8), .DIR(TB_DIR)) dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .d(d), .sin(sin),
        .start(start), .len(len), .q(q), .qb(qb), .sout(sout),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Shift as value arithmetic: halving/doubling plus the fill bit weight.
    function automatic logic [7:0] shift_model(input logic [7:0] v, input bit right, input logic s);
        int fill, r;
        if (ROT) fill = right ? (int'(v) % 2) : (int'(v) / 128);
        else     fill = int'(s);
        if (right) r = int'(v) / 2 + fill * 128;
        else       r = (int'(v) * 2) % 256 + fill;
        return 8'(r);
    endfunction

    function automatic logic model_sout(input logic [7:0] v);
        return (TB_DIR != 0) ? v[7] : v[0];
    endfunction

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; op = 2'b11; d = 8'h5A; start = 1'b1; sin = 1'b1; len = 4'd3;
        tick; tick;
        total++; if (q !== 8'h00)  begin bad++; $display("FAIL reset_q: got %h want 00", q); end
        total++; if (qb !== 8'hFF) begin bad++; $display("FAIL reset_qb: got %h want ff", qb); end
        total++; if (sout !== 1'b0) begin bad++; $display("FAIL reset_sout: got %b want 0", sout); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        rst = 1'b0; start = 1'b0; en = 1'b0;
        tick;
        mq = 8'h00;
    endtask

    task automatic test_manual_fixed;
        start = 1'b0; en = 1'b1;
        op = 2'b11; d = 8'hA5; tick; mq = 8'hA5;
        total++; if (q !== 8'hA5) begin bad++; $display("FAIL man_load: got %h want a5", q); end
        op = 2'b01; sin = 1'b1; d = 8'h00; tick; mq = shift_model(mq, 1'b1, 1'b1);
        total++; if (q !== mq) begin bad++; $display("FAIL man_shr: got %h want %h", q, mq); end
        op = 2'b10; sin = 1'b0; tick; mq = shift_model(mq, 1'b0, 1'b0);
        total++; if (q !== mq) begin bad++; $display("FAIL man_shl: got %h want %h", q, mq); end
        en = 1'b0; op = 2'b11; d = 8'hFF; tick;
        total++; if (q !== mq) begin bad++; $display("FAIL man_hold: got %h want %h", q, mq); end
        en = 1'b1; op = 2'b00; tick;
        total++; if (q !== mq) begin bad++; $display("FAIL man_op_hold: got %h want %h", q, mq); end
    endtask

    task automatic test_manual_random;
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            en = 1'($urandom); op = 2'($urandom); d = 8'($urandom); sin = 1'($urandom);
            tick;
            if (en) begin
                case (op)
                    2'b01:   mq = shift_model(mq, 1'b1, sin);
                    2'b10:   mq = shift_model(mq, 1'b0, sin);
                    2'b11:   mq = d;
                    default: mq = mq;
                endcase
            end
            total++; if (q !== mq) begin bad++; $display("FAIL rnd_q[%0d]: got %h want %h", i, q, mq); end
            total++; if (qb !== ~mq) begin bad++; $display("FAIL rnd_qb[%0d]: got %h want %h", i, qb, ~mq); end
            total++; if (sout !== model_sout(mq)) begin bad++; $display("FAIL rnd_sout[%0d]: got %b want %b", i, sout, model_sout(mq)); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_busy[%0d]: got %b want 0", i, busy); end
        end
        en = 1'b0;
    endtask

    // Start a burst (with en/op=01 asserted alongside) and follow it cycle by cycle.
    task automatic run_burst(input logic [7:0] dv, input logic [3:0] lv, input bit rand_sin,
                             input bit junk, output int done_at, output logic [7:0] souts);
        int n;
        n = (lv > 4'd8) ? 8 : int'(lv);
        d = dv; len = lv; start = 1'b1; en = 1'b1; op = 2'b01;
        sin = rand_sin ? 1'($urandom) : 1'b0;
        tick;
        start = 1'b0; en = 1'b0;
        mq = dv; done_at = 0; souts = 8'h00;
        for (int c = 1; c <= n + 2; c++) begin
            total++; if (q !== mq) begin bad++; $display("FAIL burst_q[c%0d]: got %h want %h", c, q, mq); end
            total++; if (sout !== model_sout(mq)) begin bad++; $display("FAIL burst_sout[c%0d]: got %b want %b", c, sout, model_sout(mq)); end
            total++; if (busy !== (c <= n + 1)) begin bad++; $display("FAIL burst_busy[c%0d]: got %b want %b", c, busy, (c <= n + 1)); end
            total++; if (done !== (c == n + 2)) begin bad++; $display("FAIL burst_done[c%0d]: got %b want %b", c, done, (c == n + 2)); end
            if (done === 1'b1 && done_at == 0) done_at = c;
            if (c <= 8) souts[c-1] = sout;
            if (c < n + 2) begin
                sin = rand_sin ? 1'($urandom) : 1'b0;
                if (junk) begin
                    start = 1'($urandom); en = 1'($urandom); op = 2'($urandom);
                    d = 8'($urandom); len = 4'($urandom);
                end
                tick;
                if (c <= n) mq = shift_model(mq, TB_DIR == 0, sin);
            end
        end
        start = 1'b0; en = 1'b0;
        tick;
        total++; if (q !== mq) begin bad++; $display("FAIL burst_idle_q: got %h want %h", q, mq); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL burst_idle_flags: got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_burst_fixed;
        int dat;
        logic [7:0] so;
        run_burst(8'h96, 4'd8, 1'b0, 1'b0, dat, so);
        total++; if (so !== 8'h96) begin bad++; $display("FAIL burst96_sout_seq: got %b want 10010110 (cycle8..1)", so); end
        total++; if (dat != 10) begin bad++; $display("FAIL burst96_done_cycle: got %0d want 10", dat); end
        total++; if (!ROT && q !== 8'h00) begin bad++; $display("FAIL burst96_final: got %h want 00", q); end
    endtask

    task automatic test_boundaries;
        int dat;
        logic [7:0] so, dv;
        dv = 8'($urandom);
        run_burst(dv, 4'd0, 1'b1, 1'b0, dat, so);
        total++; if (q !== dv) begin bad++; $display("FAIL len0_q: got %h want %h", q, dv); end
        total++; if (dat != 2) begin bad++; $display("FAIL len0_done_cycle: got %0d want 2", dat); end
        run_burst(8'($urandom), 4'd15, 1'b1, 1'b0, dat, so);
        total++; if (dat != 10) begin bad++; $display("FAIL len15_done_cycle: got %0d want 10", dat); end
    endtask

    task automatic test_back_to_back;
        int dat;
        logic [7:0] so;
        logic [3:0] lv;
        for (int i = 0; i < 12; i++) begin
            lv = 4'($urandom);
            run_burst(8'($urandom), lv, 1'b1, 1'b1, dat, so);
            total++; if (dat != ((lv > 4'd8) ? 10 : int'(lv) + 2)) begin bad++; $display("FAIL b2b_done_cycle[%0d]: got %0d len %0d", i, dat, lv); end
        end
    endtask

    task automatic test_reset_mid_burst;
        d = 8'($urandom) | 8'h01; len = 4'd8; start = 1'b1; sin = 1'b1;
        tick;
        start = 1'b0;
        tick; tick; tick;
        rst = 1'b1;
        tick;
        total++; if (q !== 8'h00)  begin bad++; $display("FAIL midrst_q: got %h want 00", q); end
        total++; if (qb !== 8'hFF) begin bad++; $display("FAIL midrst_qb: got %h want ff", qb); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick;
            total++; if (done !== 1'b0 || q !== 8'h00) begin bad++; $display("FAIL midrst_after[%0d]: got done=%b q=%h want 0 00", c, done, q); end
        end
        rst = 1'b1; start = 1'b1; en = 1'b1; op = 2'b11; d = 8'hFF;
        tick;
        total++; if (q !== 8'h00 || busy !== 1'b0) begin bad++; $display("FAIL rst_priority: got q=%h busy=%b want 00 0", q, busy); end
        rst = 1'b0; start = 1'b0; en = 1'b0;
        tick;
        mq = 8'h00;
    endtask

`ifdef USR_ROTATE_EN
    task automatic test_rotate;
        int dat;
        logic [7:0] so;
        run_burst(8'h81, 4'd1, 1'b1, 1'b0, dat, so);
        total++; if (q !== 8'hC0) begin bad++; $display("FAIL rot_len1: got %h want c0", q); end
        run_burst(8'hC0, 4'd8, 1'b1, 1'b0, dat, so);
        total++; if (q !== 8'hC0) begin bad++; $display("FAIL rot_len8: got %h want c0", q); end
    endtask
`endif

    initial begin
        test_reset;
        test_manual_fixed;
        test_manual_random;
        test_burst_fixed;
        test_boundaries;
        test_back_to_back;
        test_reset_mid_burst;
`ifdef USR_ROTATE_EN
        test_rotate;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
